// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: geometry constants and the read-side controller states.
package fifo_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int DEPTH      = 16;
  localparam int ADDR_WIDTH = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } rd_state_e;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus valid/ready stream, bundled for the read-side master.
interface fifo_stream_reader_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  fifo_empty;
  logic                  fifo_underflow;
  logic [DATA_WIDTH-1:0] fifo_data_out;
  logic                  fifo_read_en;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (
    input  fifo_empty, fifo_underflow, fifo_data_out, m_ready,
    output fifo_read_en, m_valid, m_data
  );

  modport slave (
    output fifo_empty, fifo_underflow, fifo_data_out, m_ready,
    input  fifo_read_en, m_valid, m_data
  );

endinterface

// File: rtl/fifo_rd_skid.sv
// Two-entry in-order buffer; head entry is the registered stream output.
module fifo_rd_skid #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [1:0]            occ
);

  logic [DATA_WIDTH-1:0] head_p1;
  logic [DATA_WIDTH-1:0] tail_p1;
  logic [1:0]            occ_p1;

  // stage 1: capture of the word returned by the FIFO
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_p1 <= '0;
      tail_p1 <= '0;
      occ_p1  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ_p1 == 2'd0) head_p1 <= din;
          else                tail_p1 <= din;
          occ_p1 <= occ_p1 + 2'd1;
        end
        2'b01: begin
          head_p1 <= tail_p1;
          occ_p1  <= occ_p1 - 2'd1;
        end
        2'b11: begin
          // simultaneous capture and pop: occupancy is unchanged
          if (occ_p1 == 2'd2) begin
            head_p1 <= tail_p1;
            tail_p1 <= din;
          end else begin
            head_p1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = head_p1;
  assign occ  = occ_p1;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side master for the synchronous FIFO: credit-based reads into a 2-entry buffer feeding a stream.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 clr_stats,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] words_read,
  output logic                 err_underflow,
  fifo_stream_reader_if.master bus
);

  rd_state_e             state;
  rd_state_e             state_nxt;
  logic                  inflight_p0;
  logic [1:0]            occ;
  logic                  pop;
  logic [2:0]            credit;
  logic [DATA_WIDTH-1:0] head;

  assign pop    = bus.m_valid & bus.m_ready;
  // a same-cycle pop frees a slot, which sustains one word per cycle
  assign credit = {1'b0, occ} + {2'b00, inflight_p0} - {2'b00, pop};

  assign bus.fifo_read_en = (state == ACTIVE) & ~bus.fifo_empty & (credit < 3'd2);
  assign bus.m_valid      = (occ != 2'd0);
  assign bus.m_data       = head;
  assign busy             = inflight_p0 | (occ != 2'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = ACTIVE;
      ACTIVE:  if (!enable) state_nxt = DRAIN;
      DRAIN: begin
        if (enable)                                 state_nxt = ACTIVE;
        else if (!inflight_p0 && (occ == 2'd0))     state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // stage 0: read issued, data returns from the FIFO next cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) inflight_p0 <= 1'b0;
    else          inflight_p0 <= bus.fifo_read_en;
  end

  fifo_rd_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (inflight_p0),
    .din     (bus.fifo_data_out),
    .pop     (pop),
    .head    (head),
    .occ     (occ)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      words_read    <= '0;
      err_underflow <= 1'b0;
    end else if (clr_stats) begin
      words_read    <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (pop)                words_read    <= words_read + 1'b1;
      if (bus.fifo_underflow) err_underflow <= 1'b1;
    end
  end

  a_no_overrun: assert property (@(posedge clk) disable iff (!reset_n)
    ({1'b0, occ} + {2'b00, inflight_p0}) <= 3'd2);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader driven by a behavioural 1-cycle-latency FIFO.
module tb_fifo_stream_reader;
  import fifo_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        clr_stats = 1'b0;
  logic        busy, busy4;
  logic [15:0] words_read;
  logic [3:0]  words_read4;
  logic        err_underflow, err_underflow4;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  logic       hold_vld = 1'b0;
  logic [7:0] hold_dat = 8'h00;

  always #5 clk = ~clk;

  fifo_stream_reader_if #(.DATA_WIDTH(8)) bus ();
  fifo_stream_reader_if #(.DATA_WIDTH(8)) bus4 ();

  fifo_stream_reader #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .clr_stats     (clr_stats),
    .busy          (busy),
    .words_read    (words_read),
    .err_underflow (err_underflow),
    .bus           (bus.master)
  );

  // narrow-counter copy sees identical inputs, so it behaves cycle-for-cycle like dut
  assign bus4.fifo_empty     = bus.fifo_empty;
  assign bus4.fifo_underflow = bus.fifo_underflow;
  assign bus4.fifo_data_out  = bus.fifo_data_out;
  assign bus4.m_ready        = bus.m_ready;

  fifo_stream_reader #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut4 (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .clr_stats     (clr_stats),
    .busy          (busy4),
    .words_read    (words_read4),
    .err_underflow (err_underflow4),
    .bus           (bus4.master)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_words(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(base + 8'(i));
      exp_q.push_back(base + 8'(i));
    end
    bus.fifo_empty = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < max) begin
      tick(1);
      k++;
    end
    if (k >= max) chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic pulse_clr();
    clr_stats = 1'b1;
    tick(1);
    clr_stats = 1'b0;
  endtask

  initial begin
    int n_rd;
    int extra;
    int k;
    bus.fifo_empty     = 1'b1;
    bus.fifo_underflow = 1'b0;
    bus.fifo_data_out  = 8'h00;
    bus.m_ready        = 1'b0;

    fork
      forever begin
        @(posedge clk);
        if (bus.fifo_read_en && fifo_q.size() != 0) bus.fifo_data_out <= fifo_q.pop_front();
        bus.fifo_empty <= (fifo_q.size() == 0);
      end
      forever begin
        @(negedge clk);
        if (reset_n) begin
          if (bus.fifo_read_en) chk("rd_while_empty", bus.fifo_empty, 0);
          if (hold_vld) begin
            chk("valid_held", bus.m_valid, 1);
            chk("data_stable", bus.m_data, hold_dat);
          end
          hold_vld = 1'b0;
          if (bus.m_valid) begin
            if (bus.m_ready) begin
              if (exp_q.size() == 0) chk("sb_underrun", exp_q.size(), 1);
              else                   chk("beat", bus.m_data, exp_q.pop_front());
            end else begin
              hold_vld = 1'b1;
              hold_dat = bus.m_data;
            end
          end
        end else begin
          hold_vld = 1'b0;
        end
      end
    join_none

    tick(3);
    chk("rst_read_en", bus.fifo_read_en, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_data", bus.m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_words", words_read, 0);
    chk("rst_err", err_underflow, 0);
    reset_n = 1'b1;
    tick(2);

    // 1: full-throughput drain of 8 words
    push_words(8, 8'h11);
    bus.m_ready = 1'b1;
    enable = 1'b1;
    #1;
    chk("t1_rd_en_idle", bus.fifo_read_en, 0);
    tick(1);
    chk("t1_first_read", bus.fifo_read_en, 1);
    tick(1);
    chk("t1_valid_early", bus.m_valid, 0);
    tick(1);
    chk("t1_valid_rise", bus.m_valid, 1);
    chk("t1_first_data", bus.m_data, 8'h11);
    tick(8);
    chk("t1_words", words_read, 8);
    chk("t1_busy_fall", busy, 0);
    chk("t1_valid_fall", bus.m_valid, 0);
    enable = 1'b0;
    tick(3);

    // 2: back-pressure pattern 1,0,0
    pulse_clr();
    push_words(6, 8'h20);
    enable = 1'b1;
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < 200) begin
      bus.m_ready = (k % 3 == 0);
      tick(1);
      k++;
    end
    if (k >= 200) chk("t2_timeout", exp_q.size(), 0);
    chk("t2_words", words_read, 6);
    chk("t2_fifo_empty", bus.fifo_empty, 1);
    enable = 1'b0;
    bus.m_ready = 1'b1;
    tick(3);

    // 3: drop enable after three reads
    pulse_clr();
    push_words(12, 8'h40);
    enable = 1'b1;
    n_rd = 0;
    k = 0;
    while (n_rd < 3 && k < 50) begin
      @(negedge clk);
      if (bus.fifo_read_en) n_rd++;
      k++;
    end
    enable = 1'b0;
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.fifo_read_en) extra++;
    end
    chk("t3_no_more_reads", extra, 0);
    chk("t3_words", words_read, 3);
    chk("t3_busy", busy, 0);
    chk("t3_fifo_left", fifo_q.size(), 9);
    chk("t3_idle", dut.state, IDLE);
    exp_q = fifo_q;
    tick(1);

    // 4: sticky underflow, clear winning over pop and underflow
    bus.fifo_underflow = 1'b1;
    tick(1);
    bus.fifo_underflow = 1'b0;
    chk("t4_err_set", err_underflow, 1);
    tick(3);
    chk("t4_err_sticky", err_underflow, 1);
    enable = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.m_valid && k < 20);
    clr_stats = 1'b1;
    bus.fifo_underflow = 1'b1;
    @(posedge clk);
    #1;
    clr_stats = 1'b0;
    bus.fifo_underflow = 1'b0;
    chk("t4_clr_words", words_read, 0);
    chk("t4_clr_err", err_underflow, 0);
    wait_idle(60);
    chk("t4_words_after", words_read, 8);
    enable = 1'b0;
    tick(3);

    // 5: asynchronous reset with a full buffer
    pulse_clr();
    push_words(10, 8'h60);
    bus.m_ready = 1'b0;
    enable = 1'b1;
    tick(6);
    chk("t5_stalled_full", bus.m_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_read_en", bus.fifo_read_en, 0);
    chk("t5_m_valid", bus.m_valid, 0);
    chk("t5_m_data", bus.m_data, 0);
    chk("t5_busy", busy, 0);
    chk("t5_err", err_underflow, 0);
    exp_q = fifo_q;
    @(negedge clk);
    reset_n = 1'b1;
    bus.m_ready = 1'b1;
    wait_idle(60);
    chk("t5_words", words_read, 8);
    chk("t5_fifo_left", fifo_q.size(), 0);

    // 6: narrow counter wraps
    pulse_clr();
    push_words(17, 8'h80);
    wait_idle(100);
    chk("t6_words16", words_read, 17);
    chk("t6_words4_wrap", words_read4, 1);
    enable = 1'b0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
